// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and default bit timing.
// Imported by the transmitter and the receiver.
package uart_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } uart_state_e;

    // Parity mode encodings
    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    // 50 MHz / 115200 baud
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

    localparam int unsigned DATA_BITS = 8;

endpackage

// File: rtl/uart_fifo_transmitter_if.sv
// Show-ahead FIFO read port plus serial-side status of the UART transmitter.
//   enable     : permits fetching a new byte
//   fifo_empty : FIFO empty flag
//   fifo_data  : FIFO head, valid whenever fifo_empty is low
//   fifo_read  : one-cycle pop strobe per byte
//   tx         : serial line, idle high
//   busy       : a frame is in progress
//   tx_done    : pulse on the last stop-bit cycle
// master = FIFO/host side, slave = transmitter.
interface uart_fifo_transmitter_if;

    logic       enable;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_read;
    logic       tx;
    logic       busy;
    logic       tx_done;

    modport master (
        output enable,
        output fifo_empty,
        output fifo_data,
        input  fifo_read,
        input  tx,
        input  busy,
        input  tx_done
    );

    modport slave (
        input  enable,
        input  fifo_empty,
        input  fifo_data,
        output fifo_read,
        output tx,
        output busy,
        output tx_done
    );

endinterface

// File: rtl/uart_baud_counter.sv
// Down-counter timing one UART bit period.
//   clock, reset : clock, synchronous active-high reset
//   load_i       : reload with CLKS_PER_BIT-1 (wins over dec_i)
//   dec_i        : decrement by one
//   count_o      : current count (registered)
//   tc_c_o       : terminal count, count is zero (combinational)
module uart_baud_counter #(
    parameter  int unsigned CLKS_PER_BIT = 434,
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load_i,
    input  logic          dec_i,
    output logic [CW-1:0] count_o,
    output logic          tc_c_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Reload has priority so a bit boundary restarts timing in the same cycle
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = CW'(CLKS_PER_BIT - 1);
        end else if (dec_i) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_c_o  = (count_q == '0);

endmodule

// File: rtl/uart_fifo_transmitter.sv
// UART transmitter draining a show-ahead byte FIFO: 8 data bits LSB-first,
// optional parity, 1 or 2 stop bits, back-to-back frames without idle gap.
//   clock, reset : clock, synchronous active-high reset
//   bus          : FIFO read port and serial status (slave modport)
module uart_fifo_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned PARITY       = PARITY_NONE,
    parameter int unsigned STOP_BITS    = 1
) (
    input logic                    clock,
    input logic                    reset,
    uart_fifo_transmitter_if.slave bus
);

    localparam int unsigned CW     = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW     = $clog2(DATA_BITS);
    localparam bit          PAR_EN  = (PARITY != PARITY_NONE);
    localparam bit          PAR_INV = (PARITY == PARITY_ODD);

    uart_state_e     state_q, state_d;
    logic [7:0]      shift_q, shift_d;
    logic [BW-1:0]   bit_idx_q, bit_idx_d;
    logic            stop_idx_q, stop_idx_d;
    logic            par_q, par_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            fifo_read_q, fifo_read_d;
    logic            tx_done_q, tx_done_d;

    logic            cnt_load;
    logic            cnt_dec;
    logic [CW-1:0]   cnt;
    logic            cnt_tc;
    logic            last_stop;
    logic            do_fetch;

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clock   (clock),
        .reset   (reset),
        .load_i  (cnt_load),
        .dec_i   (cnt_dec),
        .count_o (cnt),
        .tc_c_o  (cnt_tc)
    );

    assign cnt_dec   = (state_q != IDLE);
    assign last_stop = (stop_idx_q == 1'(STOP_BITS - 1));

    // Fetch is decided in IDLE or at the very end of the last stop bit
    assign do_fetch = bus.enable && !bus.fifo_empty &&
                      ((state_q == IDLE) || (state_q == STOP && cnt_tc && last_stop));

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        stop_idx_d  = stop_idx_q;
        par_d       = par_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        fifo_read_d = 1'b0;
        tx_done_d   = 1'b0;
        cnt_load    = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
            START: begin
                if (cnt_tc) begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                    par_d     = 1'b0;
                    cnt_load  = 1'b1;
                end
            end
            DATA: begin
                if (cnt_tc) begin
                    par_d    = par_q ^ shift_q[0];
                    shift_d  = {1'b0, shift_q[7:1]};
                    cnt_load = 1'b1;
                    if (bit_idx_q == BW'(DATA_BITS - 1)) begin
                        if (PAR_EN) begin
                            state_d = PAR;
                            tx_d    = par_q ^ shift_q[0] ^ PAR_INV;
                        end else begin
                            state_d    = STOP;
                            tx_d       = 1'b1;
                            stop_idx_d = 1'b0;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                        tx_d      = shift_q[1];
                    end
                end
            end
            PAR: begin
                if (cnt_tc) begin
                    state_d    = STOP;
                    tx_d       = 1'b1;
                    stop_idx_d = 1'b0;
                    cnt_load   = 1'b1;
                end
            end
            STOP: begin
                // Registered pulse lands on the final cycle of the last stop bit
                if (last_stop && cnt == CW'(1)) begin
                    tx_done_d = 1'b1;
                end
                if (cnt_tc) begin
                    if (last_stop) begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                        cnt_load   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Fetch overrides the IDLE/STOP outcome and starts the next frame
        if (do_fetch) begin
            state_d     = START;
            shift_d     = bus.fifo_data;
            fifo_read_d = 1'b1;
            tx_d        = 1'b0;
            busy_d      = 1'b1;
            cnt_load    = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
            par_q       <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            fifo_read_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            stop_idx_q  <= stop_idx_d;
            par_q       <= par_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            fifo_read_q <= fifo_read_d;
            tx_done_q   <= tx_done_d;
        end
    end

    assign bus.tx        = tx_q;
    assign bus.busy      = busy_q;
    assign bus.fifo_read = fifo_read_q;
    assign bus.tx_done   = tx_done_q;

endmodule

// File: tb/tb_uart_fifo_transmitter.sv
// Directed bench for uart_fifo_transmitter with CLKS_PER_BIT=4.
// Main instance: no parity, 1 stop. Two small instances cover even/2-stop and odd/1-stop.
module tb_uart_fifo_transmitter;

    logic clock = 1'b0;
    logic reset;
    logic en;
    logic en_p;

    always #5 clock = ~clock;

    uart_fifo_transmitter_if ifm ();
    uart_fifo_transmitter_if ife ();
    uart_fifo_transmitter_if ifo ();

    uart_fifo_transmitter #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) dut (
        .clock (clock), .reset (reset), .bus (ifm.slave));
    uart_fifo_transmitter #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2)) dut_e (
        .clock (clock), .reset (reset), .bus (ife.slave));
    uart_fifo_transmitter #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) dut_o (
        .clock (clock), .reset (reset), .bus (ifo.slave));

    // Show-ahead FIFO model for the main instance
    logic [7:0]  mem [16];
    int unsigned rd = 0;
    int unsigned wr = 0;

    assign ifm.enable     = en;
    assign ifm.fifo_empty = (rd == wr);
    assign ifm.fifo_data  = mem[rd[3:0]];

    always @(posedge clock) begin
        if (ifm.fifo_read && rd != wr) rd <= rd + 1;
    end

    // One-byte sources (0x03) for the parity instances
    logic pe_popped = 1'b0;
    logic po_popped = 1'b0;

    assign ife.enable     = en_p;
    assign ife.fifo_empty = pe_popped;
    assign ife.fifo_data  = 8'h03;
    assign ifo.enable     = en_p;
    assign ifo.fifo_empty = po_popped;
    assign ifo.fifo_data  = 8'h03;

    always @(posedge clock) begin
        if (ife.fifo_read) pe_popped <= 1'b1;
        if (ifo.fifo_read) po_popped <= 1'b1;
    end

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr[3:0]] = b;
        wr = wr + 1;
    endtask

    // Waits for a pop strobe on the main instance; lat = negedges waited
    task automatic wait_fetch(input string tag, output int unsigned lat);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (ifm.fifo_read !== 1'b1 && lat < 200);
        check({tag, ".fetch"}, 32'(ifm.fifo_read), 32'd1);
    endtask

    task automatic idle_check(input string tag);
        check({tag, ".idle_busy"}, 32'(ifm.busy), 32'd0);
        check({tag, ".idle_tx"}, 32'(ifm.tx), 32'd1);
        check({tag, ".idle_rd"}, 32'(ifm.fifo_read), 32'd0);
    endtask

    // Called on the first cycle of a frame (pop strobe visible); ends on its last cycle.
    // seq[k] is the hand-derived line level of bit slot k (start, d0..d7, stop).
    task automatic check_frame(input string tag, input logic [9:0] seq);
        int unsigned busy_lo  = 0;
        int unsigned extra_rd = 0;
        check({tag, ".rd0"}, 32'(ifm.fifo_read), 32'd1);
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clock);
            if (ifm.busy !== 1'b1) busy_lo++;
            if (i > 0 && ifm.fifo_read !== 1'b0) extra_rd++;
            if (i == 0) check({tag, ".tx_first"}, 32'(ifm.tx), 32'd0);
            if (i % 4 == 2)
                check($sformatf("%s.slot%0d", tag, i / 4), 32'(ifm.tx), 32'(seq[i / 4]));
            if (i == 38) check({tag, ".done_early"}, 32'(ifm.tx_done), 32'd0);
            if (i == 39) check({tag, ".done"}, 32'(ifm.tx_done), 32'd1);
        end
        check({tag, ".busy_gap"}, busy_lo, 32'd0);
        check({tag, ".extra_rd"}, extra_rd, 32'd0);
    endtask

    logic e_tx [50], e_busy [50], e_done [50];
    logic o_tx [50], o_busy [50], o_done [50];
    logic e_rd0, o_rd0;

    initial begin
        int unsigned lat;
        int unsigned rd_cnt;

        reset = 1'b1;
        en    = 1'b1;
        en_p  = 1'b0;
        push(8'h81);

        // Reset held 3 cycles with FIFO non-empty
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("rst%0d.tx", i), 32'(ifm.tx), 32'd1);
            check($sformatf("rst%0d.busy", i), 32'(ifm.busy), 32'd0);
            check($sformatf("rst%0d.rd", i), 32'(ifm.fifo_read), 32'd0);
            check($sformatf("rst%0d.done", i), 32'(ifm.tx_done), 32'd0);
        end
        reset = 1'b0;
        wait_fetch("rst", lat);
        check("rst.lat", lat, 32'd1);
        check_frame("f81", 10'b1100000010);
        @(negedge clock);
        idle_check("f81");

        // Single byte 0xA5: tx 0,1,0,1,0,0,1,0,1,1
        push(8'hA5);
        wait_fetch("a5", lat);
        check("a5.lat", lat, 32'd1);
        check_frame("a5", 10'b1101001010);
        @(negedge clock);
        idle_check("a5");

        // Back-to-back 0x55, 0xFF, 0x00
        en = 1'b0;
        push(8'h55);
        push(8'hFF);
        push(8'h00);
        @(negedge clock);
        en = 1'b1;
        wait_fetch("b2b", lat);
        check("b2b.lat", lat, 32'd1);
        check_frame("b55", 10'b1010101010);
        @(negedge clock);
        check_frame("bff", 10'b1111111110);
        @(negedge clock);
        check_frame("b00", 10'b1000000000);
        @(negedge clock);
        idle_check("b2b");

        // Enable dropped during frame 1 with a second byte queued
        push(8'h3C);
        push(8'hC3);
        wait_fetch("en", lat);
        en = 1'b0;
        check_frame("e3c", 10'b1001111000);
        rd_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (ifm.fifo_read !== 1'b0) rd_cnt++;
        end
        check("en.no_read", rd_cnt, 32'd0);
        idle_check("en");
        en = 1'b1;
        wait_fetch("en2", lat);
        check("en2.lat", lat, 32'd1);
        check_frame("ec3", 10'b1110000110);
        @(negedge clock);
        idle_check("ec3");

        // Reset during DATA bit 3 of 0x5A; 0x0F follows
        push(8'h5A);
        push(8'h0F);
        wait_fetch("mr", lat);
        repeat (17) @(negedge clock);
        check("mr.bit3", 32'(ifm.tx), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("mr.tx", 32'(ifm.tx), 32'd1);
        check("mr.busy", 32'(ifm.busy), 32'd0);
        check("mr.rd", 32'(ifm.fifo_read), 32'd0);
        check("mr.done", 32'(ifm.tx_done), 32'd0);
        reset = 1'b0;
        wait_fetch("mr2", lat);
        check("mr2.lat", lat, 32'd1);
        check_frame("m0f", 10'b1000011110);
        @(negedge clock);
        idle_check("m0f");

        // Parity instances, byte 0x03: even -> 0, odd -> 1
        en_p = 1'b1;
        @(negedge clock);
        e_rd0 = ife.fifo_read;
        o_rd0 = ifo.fifo_read;
        for (int i = 0; i < 50; i++) begin
            if (i > 0) @(negedge clock);
            e_tx[i] = ife.tx;  e_busy[i] = ife.busy;  e_done[i] = ife.tx_done;
            o_tx[i] = ifo.tx;  o_busy[i] = ifo.busy;  o_done[i] = ifo.tx_done;
        end
        check("pe.rd0", 32'(e_rd0), 32'd1);
        check("po.rd0", 32'(o_rd0), 32'd1);
        check("pe.start", 32'(e_tx[2]), 32'd0);
        check("pe.d1", 32'(e_tx[10]), 32'd1);
        check("pe.d2", 32'(e_tx[14]), 32'd0);
        check("pe.par", 32'(e_tx[38]), 32'd0);
        check("po.par", 32'(o_tx[38]), 32'd1);
        check("pe.stop1", 32'(e_tx[42]), 32'd1);
        check("pe.stop2", 32'(e_tx[46]), 32'd1);
        check("pe.done_early", 32'(e_done[43]), 32'd0);
        check("pe.done", 32'(e_done[47]), 32'd1);
        check("pe.busy_last", 32'(e_busy[47]), 32'd1);
        check("pe.busy_after", 32'(e_busy[48]), 32'd0);
        check("po.done", 32'(o_done[43]), 32'd1);
        check("po.busy_last", 32'(o_busy[43]), 32'd1);
        check("po.busy_after", 32'(o_busy[44]), 32'd0);
        check("po.tx_after", 32'(o_tx[44]), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
